fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_queue_if.sv | 37 +++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, reset PC and the fetch-buffer entry layout.
package cpu_pkg;

    localparam int              CPU_XLEN     = 32;
    localparam logic [31:0]     CPU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0]     NOP_INST     = 32'h0000_0013;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [31:0]         inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: imem request/response channels, redirect input and the decode-side output.
interface fetch_queue_if
    import cpu_pkg::*;
#(
    parameter int XLEN  = CPU_XLEN,
    parameter int DEPTH = 4
);

    logic                    imem_req_valid;
    logic                    imem_req_ready;
    logic [XLEN-1:0]         imem_req_addr;
    logic                    imem_resp_valid;
    logic                    imem_resp_ready;
    logic [31:0]             imem_resp_data;
    logic                    redirect_valid;
    logic [XLEN-1:0]         redirect_pc;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_inst;
    logic [XLEN-1:0]         out_pc;
    logic [$clog2(DEPTH):0]  dbg_count;

    modport master (
        output imem_req_valid, imem_req_addr, imem_resp_ready,
        output out_valid, out_inst, out_pc, dbg_count,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_resp_ready,
        input  out_valid, out_inst, out_pc, dbg_count,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with flush; head is read straight from the storage array.
module sync_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             full;
    logic             push_en;
    logic             pop_en;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_en) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop_en) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        if (push_en && !pop_en) begin
            count_next = count_reg + CW'(1);
        end else if (pop_en && !push_en) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Empty slots read as zero so a stale entry never leaks onto the outputs.
    assign head_data = empty ? '0 : mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited imem requests, in-order PC tagging, redirect with drop of stale responses.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              XLEN            = CPU_XLEN,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = CPU_RESET_PC
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_queue_if.master bus
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BCW = $clog2(DEPTH + 1);
    localparam int DCW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]    fpc_reg, fpc_next;
    logic [OW-1:0]      drop_cnt_reg, drop_cnt_next;
    logic [OW-1:0]      outstanding;
    logic               pcq_empty;
    logic [XLEN-1:0]    pcq_head;
    logic [BCW-1:0]     buf_count;
    logic               buf_empty;
    logic [XLEN+31:0]   buf_head;
    logic               credit_ok;
    logic               req_valid;
    logic               resp_ready;
    logic               out_valid_int;
    logic               req_fire;
    logic               resp_fire;
    logic               pop_fire;
    logic               buf_push;

    // Responses still owed to dropped requests do not occupy buffer credit.
    assign credit_ok     = (int'(buf_count) + int'(outstanding) - int'(drop_cnt_reg)) < DEPTH;
    assign req_valid     = reset_n && !bus.redirect_valid
                           && (int'(outstanding) < MAX_OUTSTANDING) && credit_ok;
    assign resp_ready    = reset_n && !pcq_empty;
    assign out_valid_int = reset_n && !buf_empty && !bus.redirect_valid;

    assign req_fire  = req_valid && bus.imem_req_ready;
    assign resp_fire = resp_ready && bus.imem_resp_valid;
    assign pop_fire  = out_valid_int && bus.out_ready;
    assign buf_push  = resp_fire && (drop_cnt_reg == '0) && !bus.redirect_valid;

    always_comb begin
        fpc_next      = fpc_reg;
        drop_cnt_next = drop_cnt_reg;
        if (bus.redirect_valid) begin
            fpc_next      = bus.redirect_pc & ~XLEN'(3);
            drop_cnt_next = outstanding - OW'(resp_fire);
        end else begin
            if (req_fire) begin
                fpc_next = fpc_reg + XLEN'(4);
            end
            if (resp_fire && (drop_cnt_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg - OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fpc_reg      <= RESET_PC;
            drop_cnt_reg <= '0;
        end else begin
            fpc_reg      <= fpc_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // The PC queue occupancy is exactly the in-flight request count.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fpc_reg),
        .pop       (resp_fire),
        .head_data (pcq_head),
        .count     (outstanding),
        .empty     (pcq_empty)
    );

    sync_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.redirect_valid),
        .push      (buf_push),
        .push_data ({pcq_head, bus.imem_resp_data}),
        .pop       (pop_fire),
        .head_data (buf_head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    assign bus.imem_req_valid  = req_valid;
    assign bus.imem_req_addr   = fpc_reg;
    assign bus.imem_resp_ready = resp_ready;
    assign bus.out_valid       = out_valid_int;
    assign bus.out_pc          = reset_n ? buf_head[XLEN+31:32] : '0;
    assign bus.out_inst        = reset_n ? buf_head[31:0] : '0;
    assign bus.dbg_count       = reset_n ? DCW'(buf_count) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model, in-order memory model, directed and random traffic.
`timescale 1ns/1ps
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam int          MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight requests carry their own drop flag, buffer is a queue of entries.
    typedef struct { logic [31:0] pc; bit dropped; } flight_t;
    flight_t     m_flight[$];
    fq_entry_t   m_buf[$];
    logic [31:0] m_fpc = RST_PC;

    // Values sampled at the falling edge, consumed at the next rising edge.
    logic        s_rst = 1'b0, s_redir = 1'b0, s_out_ready = 1'b0;
    logic [31:0] s_redir_pc = '0, s_resp_data = '0, a_req_addr = '0;
    logic        e_req_fire = 1'b0, e_resp_fire = 1'b0, e_pop = 1'b0;
    logic        a_req_fire = 1'b0, a_resp_fire = 1'b0;

    logic [31:0] req_log[$];
    fq_entry_t   pop_log[$];
    int          ncyc = 0, first_resp_nc = -1, first_outv_nc = -1;

    // Compare process.
    initial begin
        int          live;
        logic        e_req_valid, e_resp_ready, e_out_valid;
        logic [31:0] e_out_pc, e_out_inst;
        int          e_cnt;
        fq_entry_t   pe;
        forever begin
            @(negedge clk);
            ncyc++;
            live = 0;
            foreach (m_flight[i]) if (!m_flight[i].dropped) live++;
            e_req_valid  = reset_n && !bus.redirect_valid && (m_flight.size() < MAXO)
                           && ((m_buf.size() + live) < DEPTH);
            e_resp_ready = reset_n && (m_flight.size() != 0);
            e_out_valid  = reset_n && (m_buf.size() != 0) && !bus.redirect_valid;
            e_out_pc     = (reset_n && m_buf.size() != 0) ? m_buf[0].pc : 32'h0;
            e_out_inst   = (reset_n && m_buf.size() != 0) ? m_buf[0].inst : 32'h0;
            e_cnt        = reset_n ? m_buf.size() : 0;

            check("req_valid", bus.imem_req_valid, e_req_valid);
            if (e_req_valid) check("req_addr", bus.imem_req_addr, m_fpc);
            check("resp_ready", bus.imem_resp_ready, e_resp_ready);
            check("out_valid", bus.out_valid, e_out_valid);
            check("out_pc", bus.out_pc, e_out_pc);
            check("out_inst", bus.out_inst, e_out_inst);
            check("dbg_count", bus.dbg_count, e_cnt);

            s_rst       = reset_n;
            s_redir     = bus.redirect_valid;
            s_redir_pc  = bus.redirect_pc;
            s_resp_data = bus.imem_resp_data;
            s_out_ready = bus.out_ready;
            e_req_fire  = e_req_valid && bus.imem_req_ready;
            e_resp_fire = e_resp_ready && bus.imem_resp_valid;
            e_pop       = e_out_valid && bus.out_ready;
            a_req_fire  = bus.imem_req_valid && bus.imem_req_ready;
            a_req_addr  = bus.imem_req_addr;
            a_resp_fire = bus.imem_resp_valid && bus.imem_resp_ready;

            if (a_resp_fire && first_resp_nc < 0) first_resp_nc = ncyc;
            if (bus.out_valid && first_outv_nc < 0) first_outv_nc = ncyc;
            if (bus.out_valid && bus.out_ready) begin
                pe.pc = bus.out_pc;
                pe.inst = bus.out_inst;
                pop_log.push_back(pe);
                $display("pop pc=%08h inst=%08h t=%0t", bus.out_pc, bus.out_inst, $time);
            end
        end
    end

    // Model update at each rising edge.
    initial begin
        flight_t   f;
        fq_entry_t ent;
        forever begin
            @(posedge clk);
            if (a_req_fire) req_log.push_back(a_req_addr);
            if (!s_rst) begin
                m_fpc = RST_PC;
                m_flight.delete();
                m_buf.delete();
            end else begin
                if (e_pop) void'(m_buf.pop_front());
                if (e_resp_fire) begin
                    f = m_flight.pop_front();
                    if (!f.dropped && !s_redir) begin
                        ent.pc = f.pc;
                        ent.inst = s_resp_data;
                        m_buf.push_back(ent);
                    end
                end
                if (s_redir) begin
                    m_buf.delete();
                    foreach (m_flight[i]) m_flight[i].dropped = 1'b1;
                    m_fpc = {s_redir_pc[31:2], 2'b00};
                end else if (e_req_fire) begin
                    f.pc = m_fpc;
                    f.dropped = 1'b0;
                    m_flight.push_back(f);
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    end

    // In-order memory: returns addr (optionally scrambled) after a random latency.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    mem_ready_pct = 100, mem_lat_max = 1;
    bit    mem_hold = 1'b0, mem_spurious = 1'b0, mem_scramble = 1'b0;

    initial begin
        int    cyc, last_due, d;
        mreq_t r;
        cyc = 0;
        last_due = 0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!s_rst) begin
                mq.delete();
            end else begin
                if (a_resp_fire && mq.size() != 0) void'(mq.pop_front());
                if (a_req_fire) begin
                    d = cyc + ((mem_lat_max <= 1) ? 0 : $urandom_range(0, mem_lat_max - 1));
                    if (d < last_due) d = last_due;
                    last_due = d;
                    r.addr = a_req_addr;
                    r.due = d;
                    mq.push_back(r);
                end
            end
            #1;
            bus.imem_req_ready = ($urandom_range(0, 99) < mem_ready_pct);
            if (!mem_hold && mq.size() != 0 && mq[0].due <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_scramble ? (mq[0].addr ^ 32'h5A5A_C3C3) : mq[0].addr;
            end else begin
                bus.imem_resp_valid = mem_spurious && ($urandom_range(0, 3) == 0);
                bus.imem_resp_data  = $urandom;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic redirect_pulse(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick(1);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        reset_n            = 1'b0;
        tick(3);
        settle();
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_resp_ready", bus.imem_resp_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dbg_count", bus.dbg_count, 0);
        check("rst_out_pc", bus.out_pc, 0);

        // Reset release with a 1-cycle memory.
        bus.out_ready = 1'b1;
        req_log.delete();
        pop_log.delete();
        first_resp_nc = -1;
        first_outv_nc = -1;
        reset_n = 1'b1;
        for (int i = 0; i < 40 && (req_log.size() < 3 || pop_log.size() < 1); i++) tick(1);
        check("d1_progress", (req_log.size() >= 3) && (pop_log.size() >= 1), 1);
        if (req_log.size() >= 3) begin
            check("d1_req0", req_log[0], 32'h0);
            check("d1_req1", req_log[1], 32'h4);
            check("d1_req2", req_log[2], 32'h8);
        end
        if (pop_log.size() >= 1) begin
            check("d1_pop_pc", pop_log[0].pc, 32'h0);
            check("d1_pop_inst", pop_log[0].inst, 32'h0);
        end
        check("d1_latency", first_outv_nc - first_resp_nc, 1);

        // Decode stalled: buffer fills to DEPTH and requests stop.
        reset_n = 1'b0;
        bus.out_ready = 1'b0;
        tick(2);
        req_log.delete();
        pop_log.delete();
        reset_n = 1'b1;
        tick(20);
        settle();
        check("d2_dbg_count", bus.dbg_count, 4);
        check("d2_req_valid", bus.imem_req_valid, 0);
        check("d2_req_total", req_log.size(), 4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && pop_log.size() < 4; i++) tick(1);
        check("d2_drain", pop_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < pop_log.size(); i++) begin
            check("d2_pop_pc", pop_log[i].pc, 32'(4 * i));
            check("d2_pop_inst", pop_log[i].inst, 32'(4 * i));
        end

        // Redirect with two requests in flight.
        reset_n = 1'b0;
        tick(2);
        mem_hold = 1'b1;
        reset_n = 1'b1;
        redirect_pulse(32'h10);
        req_log.delete();
        for (int i = 0; i < 10 && req_log.size() < 2; i++) tick(1);
        tick(2);
        check("d3_inflight_n", req_log.size(), 2);
        if (req_log.size() >= 2) begin
            check("d3_inflight0", req_log[0], 32'h10);
            check("d3_inflight1", req_log[1], 32'h14);
        end
        req_log.delete();
        pop_log.delete();
        redirect_pulse(32'h102);
        mem_hold = 1'b0;
        for (int i = 0; i < 30 && (req_log.size() < 1 || pop_log.size() < 1); i++) tick(1);
        check("d3_progress", (req_log.size() >= 1) && (pop_log.size() >= 1), 1);
        if (req_log.size() >= 1) check("d3_next_req", req_log[0], 32'h100);
        if (pop_log.size() >= 1) begin
            check("d3_first_pc", pop_log[0].pc, 32'h100);
            check("d3_first_inst", pop_log[0].inst, 32'h100);
        end

        // Back-to-back redirects: the last one wins.
        pop_log.delete();
        redirect_pulse(32'h400);
        redirect_pulse(32'h500);
        for (int i = 0; i < 30 && pop_log.size() < 1; i++) tick(1);
        check("b2b_progress", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) check("b2b_first_pc", pop_log[0].pc, 32'h500);

        // Address wrap at the top of the address space.
        req_log.delete();
        redirect_pulse(32'hFFFF_FFF8);
        for (int i = 0; i < 30 && req_log.size() < 3; i++) tick(1);
        check("wrap_progress", req_log.size() >= 3, 1);
        if (req_log.size() >= 3) begin
            check("wrap_req0", req_log[0], 32'hFFFF_FFF8);
            check("wrap_req1", req_log[1], 32'hFFFF_FFFC);
            check("wrap_req2", req_log[2], 32'h0000_0000);
        end

        // Memory not ready for 5 cycles mid-stream.
        pop_log.delete();
        redirect_pulse(32'h200);
        tick(6);
        mem_ready_pct = 0;
        tick(5);
        mem_ready_pct = 100;
        for (int i = 0; i < 60 && pop_log.size() < 8; i++) tick(1);
        check("stall_progress", pop_log.size() >= 8, 1);
        for (int i = 0; i < 8 && i < pop_log.size(); i++)
            check("stall_order", pop_log[i].pc, 32'h200 + 32'(4 * i));

        // Reset with two requests in flight.
        mem_hold = 1'b1;
        redirect_pulse(32'h300);
        req_log.delete();
        for (int i = 0; i < 10 && req_log.size() < 2; i++) tick(1);
        check("rst2_inflight_n", req_log.size(), 2);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        mem_hold = 1'b0;
        req_log.delete();
        settle();
        check("rst2_req_valid", bus.imem_req_valid, 1);
        check("rst2_req_addr", bus.imem_req_addr, RST_PC);
        check("rst2_resp_ready", bus.imem_resp_ready, 0);
        check("rst2_out_valid", bus.out_valid, 0);
        check("rst2_dbg_count", bus.dbg_count, 0);
        check("rst2_out_inst", bus.out_inst, 0);
        for (int i = 0; i < 10 && req_log.size() < 1; i++) tick(1);
        check("rst2_progress", req_log.size() >= 1, 1);
        if (req_log.size() >= 1) check("rst2_first_req", req_log[0], RST_PC);

        // Randomized traffic against the model.
        mem_spurious  = 1'b1;
        mem_scramble  = 1'b1;
        mem_lat_max   = 4;
        mem_ready_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            bus.out_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 29) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = ($urandom_range(0, 7) == 0) ?
                                  (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
            end else begin
                bus.redirect_valid = 1'b0;
            end
            reset_n = ($urandom_range(0, 399) != 0);
            tick(1);
        end

        bus.redirect_valid = 1'b0;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        mem_spurious = 1'b0;
        mem_ready_pct = 100;
        tick(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
